// File: rtl/mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one backing-memory request/response channel between
//               the icache and dcache ports. Valid/ready arbitration with a
//               grant held until handshake; in-order read responses are routed
//               back to the issuing port through a small tag FIFO.
//               Optional build macro ARB_ROUND_ROBIN_EN selects alternating
//               priority instead of fixed dcache-over-icache priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_OUTS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req_valid,
  output logic          i_req_ready,
  input  logic [AW-1:0] i_req_addr,
  output logic          i_resp_valid,
  output logic [DW-1:0] i_resp_data,
  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic [AW-1:0] d_req_addr,
  input  logic [3:0]    d_req_we,
  input  logic [DW-1:0] d_req_wdata,
  output logic          d_resp_valid,
  output logic [DW-1:0] d_resp_data,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  output logic [3:0]    mem_req_we,
  output logic [DW-1:0] mem_req_wdata,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_resp_data,
  output logic          resp_err
);

  localparam int   PW    = $clog2(MAX_OUTS);
  localparam int   CW    = PW + 1;
  localparam logic TAG_I = 1'b0;
  localparam logic TAG_D = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                hold_port_q, hold_port_d;
  logic [MAX_OUTS-1:0] tag_q, tag_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                resp_err_q, resp_err_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic                last_grant_q, last_grant_d;
`endif

  logic fifo_full, fifo_empty, d_is_read, d_can, i_can;
  logic have_win, win_d, handshake, push, pop, head_tag;

  // Pick the port that owns the memory channel this cycle.
  always_comb begin
    // Full is judged before any same-cycle pop, so a read never sneaks in
    // on the strength of a response that is still in flight.
    fifo_full  = (count_q == CW'(MAX_OUTS));
    fifo_empty = (count_q == '0);
    d_is_read  = (d_req_we == 4'b0000);
    d_can      = d_req_valid & (~d_is_read | ~fifo_full);
    i_can      = i_req_valid & ~fifo_full;
    have_win   = 1'b0;
    win_d      = 1'b0;
    if (state_q == ST_HOLD) begin
      win_d    = hold_port_q;
      have_win = hold_port_q ? d_can : i_can;
    end
`ifdef ARB_ROUND_ROBIN_EN
    else if (d_can & i_can) begin
      have_win = 1'b1;
      win_d    = (last_grant_q == TAG_I);
    end
`endif
    else if (d_can) begin
      have_win = 1'b1;
      win_d    = 1'b1;
    end else if (i_can) begin
      have_win = 1'b1;
      win_d    = 1'b0;
    end
  end

  assign mem_req_valid = ~reset & have_win;
  assign mem_req_addr  = win_d ? d_req_addr : i_req_addr;
  assign mem_req_we    = (mem_req_valid & win_d) ? d_req_we : 4'b0000;
  assign mem_req_wdata = win_d ? d_req_wdata : '0;
  assign handshake     = mem_req_valid & mem_req_ready;
  assign d_req_ready   = handshake & win_d;
  assign i_req_ready   = handshake & ~win_d;

  assign push     = handshake & (~win_d | d_is_read);
  assign pop      = ~reset & mem_resp_valid & ~fifo_empty;
  assign head_tag = tag_q[rd_ptr_q];

  assign i_resp_valid = pop & (head_tag == TAG_I);
  assign d_resp_valid = pop & (head_tag == TAG_D);
  assign i_resp_data  = mem_resp_data;
  assign d_resp_data  = mem_resp_data;
  assign resp_err     = resp_err_q;

  // Next-state for grant FSM, tag FIFO and sticky error.
  always_comb begin
    state_d     = state_q;
    hold_port_d = hold_port_q;
    tag_d       = tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    resp_err_d  = resp_err_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
    if (handshake) last_grant_d = win_d;
`endif
    if (push) begin
      tag_d[wr_ptr_q] = win_d ? TAG_D : TAG_I;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (mem_resp_valid & fifo_empty) resp_err_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (have_win & ~mem_req_ready) begin
          state_d     = ST_HOLD;
          hold_port_d = win_d;
        end
      end
      ST_HOLD: begin
        // A requester that withdraws while held also releases the grant.
        if (handshake | ~have_win) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_port_q  <= 1'b0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= TAG_I;
`endif
    end else begin
      state_q      <= state_d;
      hold_port_q  <= hold_port_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      resp_err_q   <= resp_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//               followed by random traffic, checked every cycle against a
//               queue-based reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_OUTS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req_valid, i_req_ready, i_resp_valid;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_resp_data;
  logic          d_req_valid, d_req_ready, d_resp_valid;
  logic [AW-1:0] d_req_addr;
  logic [3:0]    d_req_we;
  logic [DW-1:0] d_req_wdata, d_resp_data;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic [3:0]    mem_req_we;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          resp_err;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_OUTS(MAX_OUTS)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: tags outstanding in issue order (0=I, 1=D), held grant,
  // sticky error and last granted port.
  bit tagq[$];
  bit m_hold, m_hold_port, m_err, m_last;
  bit m_have, m_port, m_acc_i, m_acc_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    tagq.delete();
    m_hold = 1'b0; m_hold_port = 1'b0; m_err = 1'b0; m_last = 1'b0;
  endtask

  task automatic model_eval();
    bit full, d_ok, i_ok;
    full = (tagq.size() >= MAX_OUTS);
    d_ok = d_req_valid && (d_req_we != 4'b0 || !full);
    i_ok = i_req_valid && !full;
    m_have = 1'b0; m_port = 1'b0;
    if (reset) begin
      m_have = 1'b0;
    end else if (m_hold) begin
      m_port = m_hold_port;
      m_have = m_port ? d_ok : i_ok;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (d_ok && i_ok) begin m_have = 1'b1; m_port = !m_last; end else
`endif
      if (d_ok) begin m_have = 1'b1; m_port = 1'b1; end
      else if (i_ok) begin m_have = 1'b1; m_port = 1'b0; end
    end
    m_acc_i = m_have && !m_port && mem_req_ready;
    m_acc_d = m_have &&  m_port && mem_req_ready;
  endtask

  task automatic model_update();
    if (reset) begin
      mdl_reset();
    end else begin
      if (mem_resp_valid) begin
        if (tagq.size() > 0) void'(tagq.pop_front());
        else m_err = 1'b1;
      end
      if (m_have && mem_req_ready) begin
        if (!m_port || d_req_we == 4'b0) tagq.push_back(m_port);
        m_last = m_port;
        m_hold = 1'b0;
      end else if (m_have && !m_hold) begin
        m_hold = 1'b1; m_hold_port = m_port;
      end else if (m_hold && !m_have) begin
        m_hold = 1'b0;
      end
    end
  endtask

  // Mid-cycle: compare every output against the model.
  task automatic mid();
    bit ei, ed;
    #4;
    model_eval();
    ei = !reset && mem_resp_valid && tagq.size() > 0 && tagq[0] == 1'b0;
    ed = !reset && mem_resp_valid && tagq.size() > 0 && tagq[0] == 1'b1;
    chk("mem_req_valid", mem_req_valid, m_have);
    chk("i_req_ready", i_req_ready, m_acc_i);
    chk("d_req_ready", d_req_ready, m_acc_d);
    chk("mem_req_we", mem_req_we, (m_have && m_port) ? d_req_we : 4'b0);
    if (m_have) chk("mem_req_addr", mem_req_addr, m_port ? d_req_addr : i_req_addr);
    if (m_have && m_port) chk("mem_req_wdata", mem_req_wdata, d_req_wdata);
    chk("i_resp_valid", i_resp_valid, ei);
    chk("d_resp_valid", d_resp_valid, ed);
    if (ei) chk("i_resp_data", i_resp_data, mem_resp_data);
    if (ed) chk("d_resp_data", d_resp_data, mem_resp_data);
    chk("resp_err", resp_err, m_err);
  endtask

  task automatic fin();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    i_req_valid = 0; i_req_addr = '0;
    d_req_valid = 0; d_req_addr = '0; d_req_we = 4'b0; d_req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic drain();
    i_req_valid = 0; d_req_valid = 0;
    while (tagq.size() > 0) begin
      mem_resp_valid = 1; mem_resp_data = $urandom;
      mid(); fin();
    end
    mem_resp_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] t4_data [3];
    logic        t4_isi  [3];
    t4_data = '{32'hA, 32'hB, 32'hC};
    t4_isi  = '{1'b1, 1'b0, 1'b1};

    idle_inputs(); reset = 1;
    @(posedge clk); #1;
    mdl_reset();

    // Reset cycle with activity on every input: all handshakes stay low.
    i_req_valid = 1; d_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1;
    mid();
    chk("rst_i_ready", i_req_ready, 0);
    chk("rst_d_ready", d_req_ready, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_we", mem_req_we, 0);
    chk("rst_resp_valid", {i_resp_valid, d_resp_valid}, 0);
    fin();
    reset = 0; idle_inputs();
    mid(); chk("rst_err", resp_err, 0); fin();

    // 1: both valid, dcache wins first, then icache.
    d_req_valid = 1; d_req_addr = 'h100; i_req_valid = 1; i_req_addr = 'h200; mem_req_ready = 1;
    mid(); chk("t1_c0_d_ready", d_req_ready, 1); chk("t1_c0_addr", mem_req_addr, 'h100);
    chk("t1_c0_i_ready", i_req_ready, 0); fin();
    d_req_valid = 0;
    mid(); chk("t1_c1_i_ready", i_req_ready, 1); chk("t1_c1_addr", mem_req_addr, 'h200); fin();
    i_req_valid = 0;
    drain();
    // Continuous contention: grants follow the priority policy.
    d_req_valid = 1; i_req_valid = 1; mem_req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      d_req_addr = 'h500 + 4 * k; i_req_addr = 'h600 + 4 * k;
      mid(); fin();
    end
    drain();

    // 2: icache held under backpressure while dcache arrives.
    i_req_valid = 1; i_req_addr = 'h300; mem_req_ready = 0;
    mid(); chk("t2_c0_addr", mem_req_addr, 'h300); fin();
    d_req_valid = 1; d_req_addr = 'h400;
    mid(); chk("t2_c1_addr", mem_req_addr, 'h300); chk("t2_c1_d_ready", d_req_ready, 0); fin();
    mid(); chk("t2_c2_addr", mem_req_addr, 'h300); fin();
    mem_req_ready = 1;
    mid(); chk("t2_c3_i_ready", i_req_ready, 1); chk("t2_c3_d_ready", d_req_ready, 0); fin();
    i_req_valid = 0;
    mid(); chk("t2_c4_d_ready", d_req_ready, 1); chk("t2_c4_addr", mem_req_addr, 'h400); fin();
    d_req_valid = 0;
    drain();

    // 3: fill the tag FIFO with dcache reads.
    d_req_valid = 1; d_req_we = 0; mem_req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      d_req_addr = 'h1000 + 4 * k;
      mid(); chk("t3_fill_ready", d_req_ready, 1); fin();
    end
    d_req_addr = 'h1010;
    mid(); chk("t3_full_ready", d_req_ready, 0); chk("t3_full_mvalid", mem_req_valid, 0); fin();
    d_req_we = 4'hF; d_req_wdata = 'hDEADBEEF; d_req_addr = 'h2000;
    mid(); chk("t3_wr_ready", d_req_ready, 1); chk("t3_wr_we", mem_req_we, 'hF);
    chk("t3_wr_data", mem_req_wdata, 'hDEADBEEF); fin();
    // 5: response while full; read still blocked, tag routed to dcache.
    d_req_we = 0; d_req_addr = 'h1010; mem_resp_valid = 1; mem_resp_data = 'h11;
    mid(); chk("t5_popfull_ready", d_req_ready, 0); chk("t5_popfull_dresp", d_resp_valid, 1);
    chk("t5_popfull_iresp", i_resp_valid, 0); fin();
    mem_resp_data = 'h22;
    mid(); chk("t5_pushpop_ready", d_req_ready, 1); chk("t5_pushpop_dresp", d_resp_valid, 1); fin();
    mem_resp_valid = 0; d_req_addr = 'h1014;
    mid(); chk("t5_refill_ready", d_req_ready, 1); fin();
    d_req_addr = 'h1018;
    mid(); chk("t5_full_again", d_req_ready, 0); fin();
    drain();

    // 4: I, D, I reads and in-order responses.
    mem_req_ready = 1;
    i_req_valid = 1; i_req_addr = 'h300; mid(); fin(); i_req_valid = 0;
    d_req_valid = 1; d_req_addr = 'h400; mid(); fin(); d_req_valid = 0;
    i_req_valid = 1; i_req_addr = 'h304; mid(); fin(); i_req_valid = 0;
    for (int k = 0; k < 3; k++) begin
      mem_resp_valid = 1; mem_resp_data = t4_data[k];
      mid();
      chk("t4_i_resp", i_resp_valid, t4_isi[k]);
      chk("t4_d_resp", d_resp_valid, !t4_isi[k]);
      chk("t4_data", t4_isi[k] ? i_resp_data : d_resp_data, t4_data[k]);
      fin();
    end
    mem_resp_valid = 0;
    mid(); chk("t4_pulse_end", {i_resp_valid, d_resp_valid}, 0); fin();

    // 6: stray response after reset.
    reset = 1; mid(); fin(); reset = 0;
    mem_resp_valid = 1; mem_resp_data = 'h77;
    mid(); chk("t6_no_pulse", {i_resp_valid, d_resp_valid}, 0); fin();
    mem_resp_valid = 0;
    for (int k = 0; k < 3; k++) begin mid(); chk("t6_err_sticky", resp_err, 1); fin(); end
    // Reset with a read outstanding drops its tag.
    reset = 1; mid(); fin(); reset = 0;
    i_req_valid = 1; i_req_addr = 'h800; mid(); fin(); i_req_valid = 0;
    reset = 1; mid(); fin(); reset = 0;
    mem_resp_valid = 1;
    mid(); chk("t6_drop_no_pulse", i_resp_valid, 0); fin();
    mem_resp_valid = 0;
    mid(); chk("t6_drop_err", resp_err, 1); fin();

    // Random traffic under the reference model.
    reset = 1; mid(); fin(); reset = 0; idle_inputs();
    for (int n = 0; n < 400; n++) begin
      if (!i_req_valid && ($urandom % 3 == 0)) begin
        i_req_valid = 1; i_req_addr = $urandom;
      end
      if (!d_req_valid && ($urandom % 3 == 0)) begin
        d_req_valid = 1; d_req_addr = $urandom; d_req_wdata = $urandom;
        d_req_we = ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      end
      mem_req_ready  = ($urandom % 4 != 0);
      mem_resp_valid = (tagq.size() > 0) && ($urandom % 2 == 0);
      mem_resp_data  = $urandom;
      mid(); fin();
      if (m_acc_i) i_req_valid = 0;
      if (m_acc_d) d_req_valid = 0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
